// File: rtl/mult_dot_accum.sv
// mult_dot_accum: sequential dot-product engine.
// Feeds 4-bit operand pairs to an external combinational 4x4 multiplier through
// registers. Accumulates the 8-bit products and returns the sum over valid/ready.
module mult_dot_accum #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_y,
    output logic [3:0]       mul_x,
    output logic [3:0]       mul_y,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [LEN_W-1:0] rem;
    logic             op_vld;
    logic [ACC_W:0]   sum_ext;
    logic             accept;

    // A pair is taken only while RUN holds in_ready high.
    assign accept = in_valid && (state == RUN);

    // The sum is one bit wider than acc, so the carry out of bit ACC_W-1 lands in its top bit.
    assign sum_ext = {1'b0, acc} + {{(ACC_W-7){1'b0}}, mul_p};

    // Control FSM, operand registers and accumulator share one clocked process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            ovf    <= 1'b0;
            rem    <= '0;
            op_vld <= 1'b0;
            mul_x  <= '0;
            mul_y  <= '0;
        end else begin
            // NOTE: non-blocking assignments; a later assignment in this block
            // overrides an earlier one, so the clear on start wins over accumulate.
            if (op_vld) begin
                acc <= sum_ext[ACC_W-1:0];
                if (sum_ext[ACC_W]) begin
                    ovf <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        ovf    <= 1'b0;
                        rem    <= len;
                        op_vld <= 1'b0;
                        state  <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        mul_x  <= in_x;
                        mul_y  <= in_y;
                        op_vld <= 1'b1;
                        rem    <= rem - 1'b1;
                        if (rem == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        op_vld <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The last product is added on this edge by the accumulate logic above.
                    op_vld <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and status flags decode directly from the state register.
    assign in_ready  = (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_mult_dot_accum.sv
// Testbench for mult_dot_accum. It runs two instances in lockstep: the default
// ACC_W=12 and an ACC_W=8 build for overflow. Each has a behavioural multiplier
// and a scoreboard queue of expected results.
module tb_mult_dot_accum;

    typedef struct {
        int sum;
        bit ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_x = '0;
    logic [3:0]  in_y = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic [3:0]  mul_x_a, mul_y_a;
    logic [7:0]  mul_p_a;
    logic [11:0] out_sum_a;

    logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic [3:0]  mul_x_b, mul_y_b;
    logic [7:0]  mul_p_b;
    logic [7:0]  out_sum_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   xs[16];
    int   ys[16];

    always #5 clk = ~clk;

    // Combinational 4x4 multipliers beside each engine.
    assign mul_p_a = {4'b0, mul_x_a} * {4'b0, mul_y_a};
    assign mul_p_b = {4'b0, mul_x_b} * {4'b0, mul_y_b};

    mult_dot_accum #(.ACC_W(12), .LEN_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_x(in_x), .in_y(in_y),
        .mul_x(mul_x_a), .mul_y(mul_y_a), .mul_p(mul_p_a),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_ovf(out_ovf_a), .busy(busy_a)
    );

    mult_dot_accum #(.ACC_W(8), .LEN_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_x(in_x), .in_y(in_y),
        .mul_x(mul_x_b), .mul_y(mul_y_b), .mul_p(mul_p_b),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_ovf(out_ovf_b), .busy(busy_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: modulo-2^w running sum with a sticky carry-out flag.
    function automatic exp_t model(input int w, input int n, input int mx[16], input int my[16]);
        exp_t r;
        r.sum = 0;
        r.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            r.sum += mx[i] * my[i];
            if (r.sum >= (1 << w)) begin
                r.sum -= (1 << w);
                r.ovf = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready_a"}, in_ready_a, 0);
        check({tag, "_in_ready_b"}, in_ready_b, 0);
        check({tag, "_out_valid_a"}, out_valid_a, 0);
        check({tag, "_out_sum_a"}, out_sum_a, 0);
        check({tag, "_out_ovf_a"}, out_ovf_a, 0);
        check({tag, "_busy_a"}, busy_a, 0);
        check({tag, "_busy_b"}, busy_b, 0);
        check({tag, "_mul_x_a"}, mul_x_a, 0);
        check({tag, "_mul_y_a"}, mul_y_a, 0);
        check({tag, "_out_sum_b"}, out_sum_b, 0);
    endtask

    // One complete job, entered and left on a falling edge.
    task automatic run_job(input string tag, input int n, input int gap,
                           input int stall, input bit start_in_done);
        exp_t ea, eb, ga, gb;
        ea = model(12, n, xs, ys);
        eb = model(8, n, xs, ys);
        q_a.push_back(ea);
        q_b.push_back(eb);

        start = 1'b1;
        len   = 4'(n);
        @(negedge clk);
        start = 1'b0;

        if (n == 0) begin
            check({tag, "_len0_valid"}, out_valid_a, 1);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin
                    for (int g = 0; g < gap; g++) begin
                        in_valid = 1'b0;
                        in_x     = 4'($urandom);
                        in_y     = 4'($urandom);
                        check($sformatf("%s_ready_gap%0d", tag, i), in_ready_a, 1);
                        @(negedge clk);
                    end
                end
                in_valid = 1'b1;
                in_x     = 4'(xs[i]);
                in_y     = 4'(ys[i]);
                check($sformatf("%s_ready%0d", tag, i), in_ready_a, 1);
                @(negedge clk);
            end
            in_valid = 1'b0;
            in_x     = 4'($urandom);
            in_y     = 4'($urandom);
            check({tag, "_ready_after_last"}, in_ready_a, 0);
            check({tag, "_valid_in_drain"}, out_valid_a, 0);
            @(negedge clk);
            check({tag, "_valid_latency"}, out_valid_a, 1);
        end

        for (int c = 0; c < 40; c++) begin
            if (out_valid_a) break;
            @(negedge clk);
        end
        check({tag, "_valid_timeout"}, out_valid_a, 1);
        check({tag, "_valid_b"}, out_valid_b, 1);

        ga = q_a.pop_front();
        gb = q_b.pop_front();
        check({tag, "_sum12"}, out_sum_a, ga.sum);
        check({tag, "_ovf12"}, out_ovf_a, ga.ovf);
        check({tag, "_sum8"}, out_sum_b, gb.sum);
        check({tag, "_ovf8"}, out_ovf_b, gb.ovf);

        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            start     = start_in_done && (s == 1);
            len       = 4'd3;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("%s_stall_valid%0d", tag, s), out_valid_a, 1);
            check($sformatf("%s_stall_sum%0d", tag, s), out_sum_a, ga.sum);
        end

        out_ready = 1'b1;
        start     = start_in_done;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_valid_release"}, out_valid_a, 0);
        check({tag, "_busy_release"}, busy_a, 0);
        check({tag, "_busy_release_b"}, busy_b, 0);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single pair.
        xs = '{default: 0}; ys = '{default: 0};
        xs[0] = 15; ys[0] = 15;
        run_job("single", 1, 0, 0, 1'b0);

        // Back-to-back stream.
        xs = '{default: 0}; ys = '{default: 0};
        xs[0] = 3; ys[0] = 4;
        xs[1] = 5; ys[1] = 6;
        xs[2] = 7; ys[2] = 8;
        run_job("stream", 3, 0, 0, 1'b0);

        // Stalls on input, backpressure on output, start pulsed in DONE.
        xs = '{default: 0}; ys = '{default: 0};
        xs[0] = 2; ys[0] = 9;
        xs[1] = 9; ys[1] = 2;
        run_job("stall", 2, 2, 5, 1'b1);

        // Zero length.
        xs = '{default: 0}; ys = '{default: 0};
        run_job("len0", 0, 0, 0, 1'b0);

        // Maximum length; the 8-bit build overflows here.
        xs = '{default: 15}; ys = '{default: 15};
        run_job("maxlen", 15, 0, 0, 1'b0);

        // Overflow, then a clean job clears the sticky flag.
        xs = '{default: 0}; ys = '{default: 0};
        xs[0] = 15; ys[0] = 15;
        xs[1] = 15; ys[1] = 15;
        run_job("ovf", 2, 0, 0, 1'b0);
        xs = '{default: 0}; ys = '{default: 0};
        xs[0] = 1; ys[0] = 1;
        run_job("after_ovf", 1, 0, 0, 1'b0);

        // Mid-job reset: accept 2 of 4 pairs, then reset while start and in_valid are high.
        start = 1'b1;
        len   = 4'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_x     = 4'd7;
            in_y     = 4'd5;
            @(negedge clk);
        end
        check("midrst_busy_before", busy_a, 1);
        rst      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        check_idle_outputs("midrst");
        @(negedge clk);

        xs = '{default: 0}; ys = '{default: 0};
        xs[0] = 2; ys[0] = 3;
        run_job("post_rst", 1, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_dot_accum.md
# mult_dot_accum

- Sequential dot-product engine built around the 4x4 unsigned array multiplier.
- Accepts a programmed number of 4-bit operand pairs over a valid/ready stream and drives each pair into the multiplier's X/Y inputs from registers.
- Adds the multiplier's 8-bit product into a running sum and presents the finished sum on a valid/ready output.
- The multiplier is combinational and instantiated beside this block; this block feeds it and consumes its product.

## Interface

- ACC_W, default 12: accumulator/result width; must be >= 8.
- LEN_W, default 4: width of the pair-count input.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new dot product; sampled only in IDLE.
- len  in  LEN_W  number of pairs; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_x  in  4  operand X.
- in_y  in  4  operand Y.
- mul_x  out  4  registered operand to multiplier X.
- mul_y  out  4  registered operand to multiplier Y.
- mul_p  in  8  multiplier product, combinational from mul_x/mul_y.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  accumulated sum.
- out_ovf  out  1  sticky: a carry left bit ACC_W-1 during this job.
- busy  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE, on start:
  - acc <= 0, ovf <= 0, rem <= len.
  - len == 0: go to DONE (sum 0).
  - Otherwise: go to RUN.
- start is ignored outside IDLE.
- RUN:
  - in_ready = 1.
  - On in_valid & in_ready: mul_x <= in_x, mul_y <= in_y, op_vld <= 1, rem <= rem-1.
  - Without a handshake: op_vld <= 0, and mul_x/mul_y hold.
  - When the accepted pair is the last one (rem == 1), go to DRAIN.
- Accumulate every edge in any state: if op_vld, then acc <= acc + zero-extended mul_p.
  - Addition is modulo 2^ACC_W.
  - The carry out of the addition sets ovf; ovf is sticky until the next start.
- DRAIN:
  - in_ready = 0, op_vld <= 0.
  - The final product is added on this edge; go to DONE.
- DONE:
  - out_valid = 1; out_sum = acc and out_ovf = ovf, held stable.
  - On out_ready: go to IDLE.
- in_ready is 0 in IDLE, DRAIN and DONE; in_valid is ignored there.
- Back-to-back pairs are accepted at one per cycle with no bubbles.

## Timing

- Reset (rst high at an edge), from any state:
  - State goes to IDLE.
  - acc, ovf, rem, op_vld, mul_x, mul_y all 0.
  - in_ready = 0, out_valid = 0, out_sum = 0, out_ovf = 0, busy = 0.
  - A partial sum is discarded.
  - rst has priority over start and over both handshakes in the same cycle.
- Product latency: a pair accepted at edge t appears on mul_x/mul_y after t. Its product is added to acc at edge t+1.
- Result latency: last pair accepted at edge k; DRAIN during cycle k..k+1; out_valid first high in the cycle after edge k+1.
- len == 0: out_valid high in the cycle after the start edge, with out_sum = 0.
- out_valid deasserts in the cycle after the out_ready handshake edge; busy deasserts in the same cycle.
- A start in the same cycle as the DONE handshake is ignored; start must be re-presented once in IDLE.
- in_x/in_y may change freely when no handshake occurs.

## Test plan

- Single pair: reset, start with len=1, pair (15,15).
  - Required: out_sum=225, out_ovf=0.
  - out_valid rises 2 cycles after the accept edge.
- Back-to-back stream: len=3, pairs (3,4), (5,6), (7,8) with in_valid held high.
  - Required: in_ready high for 3 consecutive cycles, then low.
  - Required: out_sum=12+30+56=98.
- Stalls and backpressure: len=2, gaps of 2 idle cycles between pairs (2,9) and (9,2), and out_ready held low 5 cycles.
  - Required: out_sum=36, stable while stalled.
  - Required: start pulsed during DONE has no effect.
- Zero length and max length:
  - len=0: out_sum=0 one cycle after start.
  - len=15 with all pairs (15,15): out_sum=3375, out_ovf=0.
- Overflow (build with ACC_W=8): len=2, pairs (15,15), (15,15).
  - Required: out_sum=194, out_ovf=1.
  - The next job, len=1 with pair (1,1): out_sum=1, out_ovf=0.
- Mid-job reset: len=4, accept 2 pairs, assert rst for one cycle.
  - Required: all outputs 0, state IDLE, in_ready=0.
  - Next job, len=1 with pair (2,3): out_sum=6.
